cpu_mem_responder: RTL

//  Memory-side responder for the single-cycle CPU: serves the 16-bit instruction fetch at PC
//  and 8-bit data read/write (Din/MW), and runs a program-load FSM ahead of execution.

---
 rtl/cpu_mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the single-cycle CPU.
// Serves instruction fetch and data read/write, and sequences the CPU:
// stream a program into IMEM, pulse CPU reset for one cycle, run until
// NEXTPC==PC, then freeze the cycle counter and report DONE.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  S_LOAD    | accepting loader words into IMEM; CPU held in reset
//  S_RELEASE | single cycle with CPU reset still high so PC loads 0
//  S_RUN     | CPU enabled; DMEM writable; CYCLES counting
//  S_HALTED  | CPU stopped (EN_L=1); CYCLES frozen; only RESET exits
module cpu_mem_responder #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_DEPTH = 256,
    parameter int CYC_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LD_VALID,
    input  logic [15:0]      LD_DATA,
    input  logic             LD_LAST,
    output logic             LD_READY,
    input  logic [7:0]       PC,
    input  logic [7:0]       NEXTPC,
    output logic [15:0]      IIN,
    input  logic [7:0]       ADDR,
    input  logic [7:0]       WDATA,
    input  logic             MW,
    output logic [7:0]       DIN,
    output logic             CPU_RESET,
    output logic             EN_L,
    output logic             DONE,
    output logic             LD_ERR,
    output logic [CYC_W-1:0] CYCLES
);

    // Word index is PC[7:1], so IMEM addressing is 7 bits; count needs one
    // extra bit to represent a completely full IMEM.
    localparam int IA_W  = 7;
    localparam int CNT_W = IA_W + 1;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ld_err_q, ld_err_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;

    logic [15:0]        imem_q [IMEM_WORDS];
    logic [7:0]         dmem_q [DMEM_DEPTH];

    logic               ld_xfer;
    logic               dmem_we;
    logic [IA_W-1:0]    wptr;
    logic [IA_W-1:0]    iidx;

    // The write pointer always equals the number of words accepted so far.
    assign wptr    = count_q[IA_W-1:0];
    assign iidx    = PC[7:1];
    assign ld_xfer = (state_q == S_LOAD) && LD_VALID;
    assign dmem_we = (state_q == S_RUN) && MW;

    // Fetch returns zero for words beyond the loaded program length.
    assign IIN    = ({1'b0, iidx} < count_q) ? imem_q[iidx] : 16'h0000;
    assign DIN    = dmem_q[ADDR];
    assign LD_ERR = ld_err_q;
    assign CYCLES = cycles_q;

    // State, program length, error flag and cycle counter registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_LOAD;
            count_q  <= '0;
            ld_err_q <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ld_err_q <= ld_err_d;
            cycles_q <= cycles_d;
        end
    end

    // Instruction memory write port, fed only by accepted loader words.
    always_ff @(posedge CLK) begin
        if (!RESET && ld_xfer) begin
            imem_q[wptr] <= LD_DATA;
        end
    end

    // Data memory write port, live only while the CPU runs.
    always_ff @(posedge CLK) begin
        if (!RESET && dmem_we) begin
            dmem_q[ADDR] <= WDATA;
        end
    end

    // Next-state logic and state-decoded CPU control outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ld_err_d  = ld_err_q;
        cycles_d  = cycles_q;
        LD_READY  = 1'b0;
        CPU_RESET = 1'b0;
        EN_L      = 1'b1;
        DONE      = 1'b0;
        case (state_q)
            S_LOAD: begin
                LD_READY  = 1'b1;
                CPU_RESET = 1'b1;
                if (LD_VALID) begin
                    count_d = count_q + 1'b1;
                    if (LD_LAST) begin
                        state_d = S_RELEASE;
                    end else if (count_q == CNT_W'(IMEM_WORDS - 1)) begin
                        state_d  = S_RELEASE;
                        ld_err_d = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                CPU_RESET = 1'b1;
                state_d   = S_RUN;
            end
            S_RUN: begin
                EN_L = 1'b0;
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (NEXTPC == PC) begin
                    state_d = S_HALTED;
                end
            end
            S_HALTED: begin
                DONE = 1'b1;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

endmodule
